// File: rtl/stream_mux_rr.sv
// Registered NCH-channel valid/ready stream mux.
// Modes: fixed select (mode=0) or round-robin over valid channels (mode=1).
module stream_mux_rr #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_ch
);

   logic            load_en;
   logic            grant;
   logic [SELW-1:0] gnt_ch;
   logic [SELW-1:0] ptr;
   int              idx;

   assign load_en = !out_valid || out_ready;

   always_comb begin
      grant  = 1'b0;
      gnt_ch = '0;
      idx    = 0;
      if (!mode) begin
         if (int'(sel) < NCH) begin
            grant  = in_valid[sel];
            gnt_ch = sel;
         end
      end else begin
         // search starts one past the last round-robin winner
         for (int i = 1; i <= NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!grant && in_valid[idx]) begin
               grant  = 1'b1;
               gnt_ch = SELW'(idx);
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && grant)
         in_ready[gnt_ch] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SELW'(NCH - 1);
      end else if (load_en) begin
         if (grant) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_ch)*WIDTH +: WIDTH];
            out_ch    <= gnt_ch;
            if (mode)
               ptr <= gnt_ch;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: spec-level model checked every cycle,
// plus directed literal checks on a 4-channel and a 3-channel instance.
module tb_stream_mux_rr;

   logic         clk = 1'b0;
   logic         rst_n;
   always #5 clk = ~clk;

   // 4-channel, 32-bit instance
   logic         mode;
   logic [1:0]   sel;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_ch;

   // 3-channel, 8-bit instance
   logic         mode3;
   logic [1:0]   sel3;
   logic [23:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [7:0]   out_data3;
   logic         out_valid3;
   logic         out_ready3;
   logic [1:0]   out_ch3;

   stream_mux_rr #(.WIDTH(32), .NCH(4)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch)
   );

   stream_mux_rr #(.WIDTH(8), .NCH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_ch(out_ch3)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model of the 4-channel instance ----------------
   bit          m_started = 0;
   bit          m_valid;
   logic [31:0] m_data;
   int          m_ch;
   int          m_last;

   // winner = valid channel at the smallest forward distance past m_last
   function automatic int pick(input logic md, input logic [1:0] s,
                               input logic [3:0] v, input int last);
      int best = -1;
      int bd = 99;
      if (!md) return v[s] ? int'(s) : -1;
      for (int c = 0; c < 4; c++) begin
         int d = (c - last - 1 + 8) % 4;
         if (v[c] && d < bd) begin
            bd = d;
            best = c;
         end
      end
      return best;
   endfunction

   function automatic logic [3:0] exp_ready();
      int g = pick(mode, sel, in_valid, m_last);
      logic [3:0] r = '0;
      if (rst_n && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      int g;
      g = pick(mode, sel, in_valid, m_last);
      if (!rst_n) begin
         m_valid = 0;
         m_data  = '0;
         m_ch    = 0;
         m_last  = 3;
      end else if (!m_valid || out_ready) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = in_data[g*32 +: 32];
            m_ch    = g;
            if (mode) m_last = g;
         end else begin
            m_valid = 0;
         end
      end
      m_started = 1;
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("model out_valid", 32'(out_valid), 32'(m_valid));
         chk("model out_data", out_data, m_data);
         chk("model out_ch", 32'(out_ch), 32'(m_ch));
         chk("model in_ready", 32'(in_ready), 32'(exp_ready()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [31:0] base);
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = base + 32'(c);
   endtask

   initial begin
      rst_n = 0; mode = 1; sel = 0; in_valid = 4'b1111; out_ready = 1;
      set_data(32'hCAFE0000);
      mode3 = 0; sel3 = 0; in_valid3 = 0; out_ready3 = 1;
      in_data3 = 24'h22_11_00;

      // reset, all valid
      next();
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'h0);
      next();
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset out_data", out_data, 32'h0);
      chk("reset out_ch", 32'(out_ch), 32'h0);
      chk("reset in_ready3", 32'(in_ready3), 32'h0);

      // fixed select sel=2
      @(posedge clk); #1;
      rst_n = 1; mode = 0; sel = 2;
      @(negedge clk);
      chk("fixed in_ready", 32'(in_ready), 32'h4);
      next();
      @(negedge clk);
      chk("fixed out_data", out_data, 32'hCAFE0002);
      chk("fixed out_ch", 32'(out_ch), 32'h2);
      chk("fixed out_valid", 32'(out_valid), 32'h1);

      // round-robin, all valid, data = index
      @(posedge clk); #1;
      mode = 1; set_data(32'h0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rr seq out_ch", 32'(out_ch), 32'(i % 4));
         chk("rr seq out_valid", 32'(out_valid), 32'h1);
      end
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rr alt out_ch", 32'(out_ch), (i % 2 == 0) ? 32'h1 : 32'h3);
         chk("rr alt out_data", out_data, (i % 2 == 0) ? 32'h1 : 32'h3);
      end

      // backpressure: hold a beat from channel 1
      in_valid = 4'b0010;
      @(posedge clk); #1;
      out_ready = 0; in_valid = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp out_ch", 32'(out_ch), 32'h1);
         chk("bp out_data", out_data, 32'h1);
         chk("bp in_ready", 32'(in_ready), 32'h0);
         next();
      end
      out_ready = 1;
      @(negedge clk);
      chk("bp release in_ready", 32'(in_ready), 32'h4);
      next();
      @(negedge clk);
      chk("bp release out_ch", 32'(out_ch), 32'h2);

      // reset mid-operation after grants 0 then 1
      in_valid = 4'b0011;
      next();
      next();
      @(negedge clk);
      chk("mid pre out_ch", 32'(out_ch), 32'h1);
      rst_n = 0; in_valid = 4'b1111;
      @(negedge clk);
      chk("mid reset in_ready", 32'(in_ready), 32'h0);
      next();
      rst_n = 1;
      @(negedge clk);
      chk("mid reset out_valid", 32'(out_valid), 32'h0);
      chk("mid first grant", 32'(in_ready), 32'h1);
      next();
      @(negedge clk);
      chk("mid first out_ch", 32'(out_ch), 32'h0);

      // mixed traffic, checked by the model
      for (int i = 0; i < 80; i++) begin
         mode = 1'($urandom_range(0, 1));
         sel = 2'($urandom_range(0, 3));
         in_valid = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
         next();
      end
      in_valid = 0; out_ready = 1;

      // 3-channel: out-of-range select
      mode3 = 0; sel3 = 3; in_valid3 = 3'b111;
      @(negedge clk);
      chk("nch3 sel3 in_ready", 32'(in_ready3), 32'h0);
      next();
      @(negedge clk);
      chk("nch3 sel3 out_valid", 32'(out_valid3), 32'h0);
      chk("nch3 sel3 in_ready2", 32'(in_ready3), 32'h0);
      sel3 = 2;
      @(negedge clk);
      chk("nch3 sel2 in_ready", 32'(in_ready3), 32'h4);
      next();
      @(negedge clk);
      chk("nch3 sel2 out_data", 32'(out_data3), 32'h22);
      // 3-channel round-robin wraps 0,1,2,0
      mode3 = 1;
      for (int i = 0; i < 4; i++) begin
         next();
         @(negedge clk);
         chk("nch3 rr out_ch", 32'(out_ch3), 32'(i % 3));
      end

      next();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-channel stream multiplexer for the datapath. It generalises the combinational 4:1 bit mux to NCH channels of WIDTH bits, each with a valid/ready handshake. It supports two modes: fixed select, and round-robin arbitration across valid channels. A single output register stage decouples the sources from the consumer, so it can sit between pipeline stages, for example when merging fetch/memory request streams.

## Interface
- WIDTH, 32, data bits per channel
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), select/channel-index width (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
- mode  input  1  0 = fixed select via sel; 1 = round-robin
- sel  input  SELW  channel index used when mode=0
- in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- out_data  output  WIDTH  registered data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready
- out_ch  output  SELW  registered index of the channel that produced out_data

## Operation
- load_en = !out_valid | out_ready: the output register is empty or is draining this cycle.
- Candidate channel c:
  - mode=0: c = sel, eligible only if sel < NCH and in_valid[sel].
  - mode=1: search (ptr+1), (ptr+2), …, ptr modulo NCH; c is the first channel with in_valid set.
  - In either mode, no eligible channel means no grant.
- in_ready[c] = load_en & grant. All other in_ready bits are 0. At most one in_ready bit is high in any cycle.
- Transfer from channel c occurs when in_valid[c] & in_ready[c]. On a transfer, at the next edge:
  - out_data ← in_data[c]
  - out_ch ← c
  - out_valid ← 1
- load_en with no transfer: out_valid ← 0; out_data and out_ch hold.
- !load_en (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold unchanged. Every in_ready is 0.
- Round-robin pointer ptr (SELW bits, internal):
  - Updates to c only on a transfer made in mode=1.
  - Holds in mode=0.
  - Never takes a value ≥ NCH.
- mode and sel are combinational into arbitration. A change takes effect in the same cycle and never corrupts a beat already in the output register.
- Data is not modified. There are no width conversions.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_ch=0, ptr=NCH-1, so the first round-robin search starts at channel 0. in_ready is forced to 0 while rst_n=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Simultaneous out_ready=1 and an input transfer in the same cycle: the old beat is consumed and the new beat is loaded. No bubble.
- Reset mid-operation: a beat held in the register is discarded (out_valid=0 next cycle). The pointer returns to NCH-1.
- Fairness in mode=1 with all channels continuously valid: grants rotate 0,1,…,NCH-1,0. Every channel is granted within NCH transfers.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 → in_ready=0; after the edge, out_valid=0, out_data=0, out_ch=0.
- Fixed select: mode=0, sel=2, in_valid=4'b1111, in_data[2]=32'hCAFE0002, out_ready=1 → in_ready=4'b0100; next cycle out_data=32'hCAFE0002, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, all valid, channel data = index, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles. Then in_valid=4'b1010 → grants alternate 1,3.
- Backpressure: a beat from channel 1 is held with out_ready=0 for 3 cycles → out_data and out_ch stable, in_ready=0; on out_ready=1 the next valid channel (2) loads in the same cycle.
- Out-of-range select: NCH=3, mode=0, sel=3, in_valid=3'b111 → in_ready=0, out_valid stays 0.
- Reset mid-operation: mode=1 after grants to 0 and 1, assert rst_n=0 for 1 cycle → out_valid=0; after release, the first grant is channel 0.
